// File: rtl/kamacore_pipeline_ctrl_if.sv
// rtl/kamacore_pipeline_ctrl_if.sv - pipeline <-> hazard controller signal bundle (KAMACORE_PIPE_PERF_EN adds perf counters)
interface kamacore_pipeline_ctrl_if #(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   // pipeline status into the controller
   logic                      id_valid;
   logic [REG_ADDR_WIDTH-1:0] id_rs1_a;
   logic [REG_ADDR_WIDTH-1:0] id_rs2_a;
   logic                      id_rs1_used;
   logic                      id_rs2_used;
   logic                      ex_valid;
   logic                      ex_mem_read;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_a;
   logic                      ex_branch_taken;
   logic [CPU_WIDTH-1:0]      ex_branch_target;
   logic                      mem_req;
   logic                      mem_ready;

   // controls back to the pipeline
   logic                      stall_if;
   logic                      stall_id;
   logic                      stall_ex;
   logic                      stall_mem;
   logic                      flush_id;
   logic                      flush_ex;
   logic                      redirect_valid;
   logic [CPU_WIDTH-1:0]      redirect_pc;
   logic                      mem_timeout;
`ifdef KAMACORE_PIPE_PERF_EN
   logic [31:0]               perf_stall_cycles;
   logic [31:0]               perf_flush_count;
`endif

   modport master (
      output id_valid, id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
      output ex_valid, ex_mem_read, ex_rd_a, ex_branch_taken, ex_branch_target,
      output mem_req, mem_ready,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
      input  redirect_valid, redirect_pc, mem_timeout
`ifdef KAMACORE_PIPE_PERF_EN
      , input perf_stall_cycles, perf_flush_count
`endif
   );

   modport slave (
      input  id_valid, id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
      input  ex_valid, ex_mem_read, ex_rd_a, ex_branch_taken, ex_branch_target,
      input  mem_req, mem_ready,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
      output redirect_valid, redirect_pc, mem_timeout
`ifdef KAMACORE_PIPE_PERF_EN
      , output perf_stall_cycles, perf_flush_count
`endif
   );
endinterface

// File: rtl/kamacore_pipeline_ctrl.sv
// rtl/kamacore_pipeline_ctrl.sv - kamacore stall/flush/redirect controller with memory-wait watchdog (KAMACORE_PIPE_PERF_EN adds perf counters)
module kamacore_pipeline_ctrl #(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   kamacore_pipeline_ctrl_if.slave bus
);
   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

   state_t               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [CPU_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic                 timeout_q, timeout_d;

   logic                 branch_c;
   logic                 hazard_c;
   logic                 resolve_c;
   logic                 stall_front_c;
   logic                 stall_back_c;
   logic                 flush_id_c;
   logic                 flush_ex_c;
   logic                 redir_c;
   logic [CPU_WIDTH-1:0] redir_pc_c;

   assign branch_c = bus.ex_valid && bus.ex_branch_taken;

   // x0 is hardwired zero, so a load targeting it never needs an interlock
   assign hazard_c = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd_a != '0) && bus.id_valid &&
                     ((bus.id_rs1_used && (bus.id_rs1_a == bus.ex_rd_a)) ||
                      (bus.id_rs2_used && (bus.id_rs2_a == bus.ex_rd_a)));

   // Control decode and next-state: a memory wait freezes everything, a branch seen while
   // frozen is parked in pend_* and replayed on the cycle the wait ends
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pend_valid_d  = pend_valid_q;
      pend_pc_d     = pend_pc_q;
      timeout_d     = timeout_q;
      resolve_c     = 1'b0;
      stall_front_c = 1'b0;
      stall_back_c  = 1'b0;
      flush_id_c    = 1'b0;
      flush_ex_c    = 1'b0;
      redir_c       = 1'b0;
      redir_pc_c    = '0;

      case (state_q)
         RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               stall_front_c = 1'b1;
               stall_back_c  = 1'b1;
               state_d       = MEM_WAIT;
               cnt_d         = 16'd1;
               if (branch_c) begin
                  pend_valid_d = 1'b1;
                  pend_pc_d    = bus.ex_branch_target;
               end
            end else begin
               resolve_c = 1'b1;
            end
         end
         MEM_WAIT: begin
            // dropping mem_req mid-wait is an abort and ends the wait like mem_ready
            if (bus.mem_req && !bus.mem_ready) begin
               stall_front_c = 1'b1;
               stall_back_c  = 1'b1;
               cnt_d         = (cnt_q >= TIMEOUT_C) ? cnt_q : cnt_q + 16'd1;
               if (branch_c && !pend_valid_q) begin
                  pend_valid_d = 1'b1;
                  pend_pc_d    = bus.ex_branch_target;
               end
            end else begin
               state_d = RUN;
               cnt_d   = 16'd0;
               if (pend_valid_q) begin
                  redir_c      = 1'b1;
                  redir_pc_c   = pend_pc_q;
                  flush_id_c   = 1'b1;
                  flush_ex_c   = 1'b1;
                  pend_valid_d = 1'b0;
               end else begin
                  resolve_c = 1'b1;
               end
            end
         end
         default: state_d = RUN;
      endcase

      // branch outranks load-use: the dependent ID instruction is flushed anyway
      if (resolve_c) begin
         if (branch_c) begin
            redir_c    = 1'b1;
            redir_pc_c = bus.ex_branch_target;
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
         end else if (hazard_c) begin
            stall_front_c = 1'b1;
            flush_ex_c    = 1'b1;
         end
      end

      if (stall_back_c && (cnt_d == TIMEOUT_C)) begin
         timeout_d = 1'b1;
      end
   end

   // State, wait counter, parked branch and sticky watchdog flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         cnt_q        <= 16'd0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.stall_if       = rst && stall_front_c;
   assign bus.stall_id       = rst && stall_front_c;
   assign bus.stall_ex       = rst && stall_back_c;
   assign bus.stall_mem      = rst && stall_back_c;
   assign bus.flush_id       = rst && flush_id_c;
   assign bus.flush_ex       = rst && flush_ex_c;
   assign bus.redirect_valid = rst && redir_c;
   assign bus.redirect_pc    = rst ? redir_pc_c : '0;
   assign bus.mem_timeout    = timeout_q;

`ifdef KAMACORE_PIPE_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   // Saturating event counters for stalled-fetch cycles and redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         if (bus.stall_if && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (bus.redirect_valid && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cycles = perf_stall_q;
   assign bus.perf_flush_count  = perf_flush_q;
`endif
endmodule
